// File: rtl/inst_rom_arbiter_pkg.sv
// Shared widths, chip-enable levels and FSM encodings for the instruction ROM arbiter.
// The debug response encoding exists only when INST_ROM_ARB_DBG_EN is defined.
package inst_rom_arbiter_pkg;

    localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;
    localparam logic        CHIP_ENABLE       = 1'b1;
    localparam logic        CHIP_DISABLE      = 1'b0;
    localparam int          INST_ADDR_BUS     = 32;
    localparam int          INST_BUS          = 32;
    localparam int          INST_MEM_NUM_LOG2 = 17;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
`ifdef INST_ROM_ARB_DBG_EN
        ST_DBG_RSP = 2'b10,
`endif
        ST_IF_RSP  = 2'b01
    } arb_state_t;

    function automatic logic misaligned(input logic [1:0] lo);
        return |lo;
    endfunction

endpackage

// File: rtl/inst_rom_arbiter_wait_cnt.sv
// Saturating starvation counter for the debug port of inst_rom_arbiter.
// Present only when INST_ROM_ARB_DBG_EN is defined.
`ifdef INST_ROM_ARB_DBG_EN
module inst_arb_wait_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int                CNT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt;

    // Clear wins over increment so a granted cycle always restarts the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_max = (cnt == CNT_MAX);

endmodule
`endif

// File: rtl/inst_rom_arbiter.sv
// Shares the combinational instruction ROM between the IF fetch port and a debug port.
// Build option INST_ROM_ARB_DBG_EN enables the debug port; otherwise it is tied off.
//
// state      | meaning
// ST_IDLE    | no word returning this cycle
// ST_IF_RSP  | response register holds an IF word
// ST_DBG_RSP | response register holds a debug word
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W   = INST_ADDR_BUS,
    parameter int DATA_W   = INST_BUS,
    parameter int MEM_LOG2 = INST_MEM_NUM_LOG2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    arb_state_t        state, state_nxt;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] dbg_addr_sel;
    logic              sel_oor;
    logic              sel_bad;

    // Grants are masked during reset so nothing is issued while rst is low.
`ifdef INST_ROM_ARB_DBG_EN
    logic wait_max;

    assign dbg_gnt      = rst & dbg_req & (wait_max | ~if_req | if_flush);
    assign if_gnt       = rst & if_req & ~if_flush & ~dbg_gnt;
    assign dbg_addr_sel = dbg_addr;

    inst_arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (dbg_req & ~dbg_gnt),
        .clr    (dbg_gnt),
        .at_max (wait_max)
    );
`else
    logic unused_dbg;

    assign unused_dbg   = ^{dbg_req, dbg_addr};
    assign dbg_gnt      = 1'b0;
    assign if_gnt       = rst & if_req & ~if_flush;
    assign dbg_addr_sel = '0;
`endif

    always_comb begin
        sel_addr = '0;
        if (if_gnt) begin
            sel_addr = if_addr;
        end else if (dbg_gnt) begin
            sel_addr = dbg_addr_sel;
        end
    end

    assign sel_oor  = |(sel_addr >> (MEM_LOG2 + 2));
    assign sel_bad  = sel_oor | misaligned(sel_addr[1:0]);
    assign rom_ce   = (if_gnt | dbg_gnt) ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom_addr = {sel_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_nxt = ST_IDLE;
        if (if_gnt) begin
            state_nxt = ST_IF_RSP;
`ifdef INST_ROM_ARB_DBG_EN
        end else if (dbg_gnt) begin
            state_nxt = ST_DBG_RSP;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (rom_ce == CHIP_ENABLE) begin
                rsp_data <= sel_oor ? DATA_W'(ZERO_WORD) : rom_inst;
                rsp_err  <= sel_bad;
            end
        end
    end

    // Outputs are forced to reset values in the reset cycle itself, dropping any pending word.
    assign if_rvalid = rst & (state == ST_IF_RSP) & ~if_flush;
    assign if_rdata  = rst ? rsp_data : '0;
    assign if_err    = if_rvalid & rsp_err;

`ifdef INST_ROM_ARB_DBG_EN
    assign dbg_rvalid = rst & (state == ST_DBG_RSP);
    assign dbg_rdata  = rst ? rsp_data : '0;
    assign dbg_err    = dbg_rvalid & rsp_err;
`else
    assign dbg_rvalid = 1'b0;
    assign dbg_rdata  = DATA_W'(ZERO_WORD);
    assign dbg_err    = 1'b0;
`endif

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Self-checking bench for inst_rom_arbiter: vector table plus a contention run,
// with expected responses queued at grant time and compared one cycle later.
module tb_inst_rom_arbiter;

`ifdef INST_ROM_ARB_DBG_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_err;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;

    always #5 clk = ~clk;

    inst_rom_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .dbg_err    (dbg_err),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h3401_1100;
            32'h4:   return 32'h3402_0020;
            32'h8:   return 32'h3403_ff00;
            default: return {a[15:0] ^ 16'h5a5a, a[15:0]};
        endcase
    endfunction

    assign rom_inst = rom_word(rom_addr);

    typedef struct {
        logic        r;
        logic        ireq;
        logic [31:0] iaddr;
        logic        flush;
        logic        dreq;
        logic [31:0] daddr;
        logic        eig;
        logic        edg;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic ireq, input logic [31:0] iaddr,
                                input logic flush, input logic dreq, input logic [31:0] daddr,
                                input logic eig, input logic edg);
        vec_t v;
        v.r = r; v.ireq = ireq; v.iaddr = iaddr; v.flush = flush;
        v.dreq = dreq; v.daddr = daddr; v.eig = eig; v.edg = edg;
        return v;
    endfunction

    function automatic rsp_t exp_rsp(input logic port, input logic [31:0] a);
        rsp_t p;
        logic oor;
        oor    = |a[31:19];
        p.port = port;
        p.data = oor ? 32'h0 : rom_word({a[31:2], 2'b00});
        p.err  = oor | (|a[1:0]);
        return p;
    endfunction

    // Entered 1 time unit after a rising edge; checks at the falling edge.
    task automatic apply(input vec_t v, input string tag);
        rsp_t        p;
        logic        eig, edg, exp_iv, exp_dv;
        logic [31:0] exp_addr;
        eig = v.eig;
        edg = v.edg;
        if (!DBG_EN) begin
            eig = v.r & v.ireq & ~v.flush;
            edg = 1'b0;
        end
        rst      = v.r;
        if_req   = v.ireq;
        if_addr  = v.iaddr;
        if_flush = v.flush;
        dbg_req  = v.dreq;
        dbg_addr = v.daddr;
        #4;
        exp_addr = eig ? {v.iaddr[31:2], 2'b00} : (edg ? {v.daddr[31:2], 2'b00} : 32'h0);
        check({tag, " if_gnt"},   32'(if_gnt),  32'(eig));
        check({tag, " dbg_gnt"},  32'(dbg_gnt), 32'(edg));
        check({tag, " rom_ce"},   32'(rom_ce),  32'(eig | edg));
        check({tag, " rom_addr"}, rom_addr,     exp_addr);

        p = '{port: 1'b0, data: 32'h0, err: 1'b0};
        exp_iv = 1'b0;
        exp_dv = 1'b0;
        if (sb.size() != 0) begin
            p      = sb.pop_front();
            exp_iv = v.r & ~p.port & ~v.flush;
            exp_dv = v.r & p.port;
        end
        check({tag, " if_rvalid"},  32'(if_rvalid),  32'(exp_iv));
        check({tag, " dbg_rvalid"}, 32'(dbg_rvalid), 32'(exp_dv));
        check({tag, " if_err"},     32'(if_err),     32'(exp_iv & p.err));
        check({tag, " dbg_err"},    32'(dbg_err),    32'(exp_dv & p.err));
        if (exp_iv) check({tag, " if_rdata"},  if_rdata,  p.data);
        if (exp_dv) check({tag, " dbg_rdata"}, dbg_rdata, p.data);
        if (!v.r) check({tag, " if_rdata reset"}, if_rdata, 32'h0);
        if (!DBG_EN || !v.r) check({tag, " dbg_rdata zero"}, dbg_rdata, 32'h0);

        if (v.r && eig) sb.push_back(exp_rsp(1'b0, v.iaddr));
        if (v.r && edg) sb.push_back(exp_rsp(1'b1, v.daddr));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[22];

    initial begin
        rst      = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h0;
        if_flush = 1'b0;
        dbg_req  = 1'b0;
        dbg_addr = 32'h0;

        // reset held, then IF-only stream
        tbl[0]  = mk(1'b0, 1'b1, 32'h0,      1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 32'h0,      1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 32'h0,      1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 1'b1, 32'h0,      1'b0, 1'b0, 32'h0,  1'b1, 1'b0);
        tbl[4]  = mk(1'b1, 1'b1, 32'h4,      1'b0, 1'b0, 32'h0,  1'b1, 1'b0);
        tbl[5]  = mk(1'b1, 1'b1, 32'h8,      1'b0, 1'b0, 32'h0,  1'b1, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        // flush kills the pending IF word and blocks the IF grant
        tbl[7]  = mk(1'b1, 1'b1, 32'hc,      1'b0, 1'b0, 32'h0,  1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 1'b1, 32'h10,     1'b1, 1'b0, 32'h0,  1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 1'b1, 32'h10,     1'b0, 1'b0, 32'h0,  1'b1, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        // misaligned and out-of-range fetches
        tbl[11] = mk(1'b1, 1'b1, 32'h2,      1'b0, 1'b0, 32'h0,  1'b1, 1'b0);
        tbl[12] = mk(1'b1, 1'b1, 32'h8_0000, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0);
        tbl[13] = mk(1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        // debug alone, then debug during a flush
        tbl[14] = mk(1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'h14, 1'b0, 1'b1);
        tbl[15] = mk(1'b1, 1'b0, 32'h0,      1'b1, 1'b1, 32'h6,  1'b0, 1'b1);
        tbl[16] = mk(1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        tbl[17] = mk(1'b1, 1'b1, 32'h20,     1'b1, 1'b1, 32'h18, 1'b0, 1'b1);
        tbl[18] = mk(1'b1, 1'b1, 32'h24,     1'b0, 1'b0, 32'h0,  1'b1, 1'b0);
        // reset right after a debug grant drops the response
        tbl[19] = mk(1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'h1c, 1'b0, 1'b1);
        tbl[20] = mk(1'b0, 1'b1, 32'h28,     1'b0, 1'b1, 32'h1c, 1'b0, 1'b0);
        tbl[21] = mk(1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,  1'b0, 1'b0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 22; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // continuous contention: IF wins four cycles, debug forced on the fifth
        for (int k = 0; k < 15; k++) begin
            apply(mk(1'b1, 1'b1, 32'h40 + 32'(4 * k), 1'b0, 1'b1, 32'h200 + 32'(4 * k),
                     (k % 5) != 4, (k % 5) == 4),
                  $sformatf("cont%0d", k));
        end
        apply(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0), "drain");

        check("scoreboard empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
